// File: rtl/mapper_pkg.sv
// Shared constants for the serial-loaded bank controller: register indices, mode encodings, reset values.
package mapper_pkg;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_CHR0 = 2'd1;
   localparam logic [1:0] REG_CHR1 = 2'd2;
   localparam logic [1:0] REG_PRG  = 2'd3;

   localparam logic [1:0] PRG_MODE_32K_A  = 2'd0;
   localparam logic [1:0] PRG_MODE_32K_B  = 2'd1;
   localparam logic [1:0] PRG_MODE_FIX_LO = 2'd2;
   localparam logic [1:0] PRG_MODE_FIX_HI = 2'd3;

   localparam logic [1:0] MIR_ONE_LO = 2'd0;
   localparam logic [1:0] MIR_ONE_HI = 2'd1;
   localparam logic [1:0] MIR_VERT   = 2'd2;
   localparam logic [1:0] MIR_HORZ   = 2'd3;

   localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
   localparam logic [4:0] CTRL_RESET  = 5'b01100;

endpackage

// File: rtl/serial_bank_ctrl_if.sv
// CPU/PPU bus bundle seen by the bank controller; the board (master) drives it, the mapper (slave) samples it.
interface serial_bank_ctrl_if;

   logic        cpu_rw;
   logic [7:0]  cpu_data;
   logic [15:0] cpu_addr;
   logic [3:0]  ppu_addr;

   modport master (output cpu_rw, output cpu_data, output cpu_addr, output ppu_addr);
   modport slave  (input  cpu_rw, input  cpu_data, input  cpu_addr, input  ppu_addr);

endinterface

// File: rtl/serial_bank_ctrl_loader.sv
// Serial write front end: qualifies ROM-space writes, drops RMW second writes, shifts bits LSB first,
// and emits a one-cycle commit (value + register index) on the fifth accepted bit.
module serial_loader
   import mapper_pkg::*;
(
   input  logic                     m2,
   input  logic                     reset,
   serial_bank_ctrl_if.slave        bus,
   output logic                     commit_o,
   output logic [4:0]               commit_val_o,
   output logic [1:0]               commit_idx_o,
   output logic                     clear_o
);

   logic [4:0] shift_q, shift_d;
   logic       prev_wr_q, prev_wr_d;
   logic       qual;
   logic       accept;
   logic [4:0] shifted;
   logic       unused_bus;

   assign unused_bus = ^{bus.cpu_data[6:1], bus.cpu_addr[12:0], bus.ppu_addr};

   always_comb begin
      qual         = bus.cpu_addr[15] & ~bus.cpu_rw;
      accept       = qual & ~prev_wr_q;
      prev_wr_d    = qual;
      shifted      = {bus.cpu_data[0], shift_q[4:1]};
      shift_d      = shift_q;
      commit_o     = 1'b0;
      clear_o      = 1'b0;
      commit_val_o = shifted;
      commit_idx_o = bus.cpu_addr[14:13];
      if (accept) begin
         if (bus.cpu_data[7]) begin
            shift_d = SHIFT_EMPTY;
            clear_o = 1'b1;
         end else if (shift_q[0]) begin
            // Sentinel bit has reached position 0: this write carries the fifth bit.
            shift_d  = SHIFT_EMPTY;
            commit_o = 1'b1;
         end else begin
            shift_d = shifted;
         end
      end
   end

   always_ff @(posedge m2) begin
      if (reset) begin
         shift_q   <= SHIFT_EMPTY;
         prev_wr_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         prev_wr_q <= prev_wr_d;
      end
   end

endmodule

// File: rtl/serial_bank_ctrl.sv
// Serial-loaded bank controller: holds ctrl/chr0/chr1/prg and decodes PRG, CHR, mirroring and WRAM strobes.
// Define WRAM_PROTECT_EN to let prg[4] disable WRAM; otherwise prg[4] is stored but has no effect.
module serial_bank_ctrl
   import mapper_pkg::*;
#(
   parameter logic [3:0] PRG_FIXED_BANK = 4'hF
) (
   input  logic        m2,
   input  logic        reset,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_data,
   input  logic [15:0] cpu_addr,
   input  logic [3:0]  ppu_addr,
   output logic [3:0]  prg_addr,
   output logic        prg_oe,
   output logic [4:0]  chr_addr,
   output logic        ciram_a10,
   output logic        ram_ce,
   output logic        ram_oe,
   output logic        ram_we
);

   serial_bank_ctrl_if cpu_bus ();

   assign cpu_bus.cpu_rw   = cpu_rw;
   assign cpu_bus.cpu_data = cpu_data;
   assign cpu_bus.cpu_addr = cpu_addr;
   assign cpu_bus.ppu_addr = ppu_addr;

   logic       commit;
   logic [4:0] commit_val;
   logic [1:0] commit_idx;
   logic       clear;

   serial_loader u_loader (
      .m2           (m2),
      .reset        (reset),
      .bus          (cpu_bus),
      .commit_o     (commit),
      .commit_val_o (commit_val),
      .commit_idx_o (commit_idx),
      .clear_o      (clear)
   );

   logic [4:0] ctrl_q, ctrl_d;
   logic [4:0] chr0_q, chr0_d;
   logic [4:0] chr1_q, chr1_d;
   logic [4:0] prg_q,  prg_d;

   always_comb begin
      ctrl_d = ctrl_q;
      chr0_d = chr0_q;
      chr1_d = chr1_q;
      prg_d  = prg_q;
      if (clear) begin
         ctrl_d = ctrl_q | CTRL_RESET;
      end else if (commit) begin
         case (commit_idx)
            REG_CTRL: ctrl_d = commit_val;
            REG_CHR0: chr0_d = commit_val;
            REG_CHR1: chr1_d = commit_val;
            default:  prg_d  = commit_val;
         endcase
      end
   end

   always_ff @(posedge m2) begin
      if (reset) begin
         ctrl_q <= CTRL_RESET;
         chr0_q <= 5'h00;
         chr1_q <= 5'h00;
         prg_q  <= 5'h00;
      end else begin
         ctrl_q <= ctrl_d;
         chr0_q <= chr0_d;
         chr1_q <= chr1_d;
         prg_q  <= prg_d;
      end
   end

   logic wram_window;
   logic wram_off;

`ifdef WRAM_PROTECT_EN
   assign wram_off = prg_q[4];
`else
   logic unused_prg_bit;
   assign unused_prg_bit = prg_q[4];
   assign wram_off       = 1'b0;
`endif

   always_comb begin
      case (ctrl_q[3:2])
         PRG_MODE_32K_A, PRG_MODE_32K_B: prg_addr = {prg_q[3:1], cpu_addr[14]};
         PRG_MODE_FIX_LO:                prg_addr = cpu_addr[14] ? prg_q[3:0] : 4'h0;
         default:                        prg_addr = cpu_addr[14] ? PRG_FIXED_BANK : prg_q[3:0];
      endcase

      // ppu_addr[2] is PPU A12, selecting the upper or lower 4K pattern half.
      if (!ctrl_q[4]) begin
         chr_addr = {chr0_q[4:1], ppu_addr[2]};
      end else begin
         chr_addr = ppu_addr[2] ? chr1_q : chr0_q;
      end

      case (ctrl_q[1:0])
         MIR_ONE_LO: ciram_a10 = 1'b0;
         MIR_ONE_HI: ciram_a10 = 1'b1;
         MIR_VERT:   ciram_a10 = ppu_addr[0];
         default:    ciram_a10 = ppu_addr[1];
      endcase

      prg_oe      = ~(cpu_addr[15] & cpu_rw);
      wram_window = (cpu_addr[15:13] == 3'b011);
      ram_ce      = ~wram_window | wram_off;
      ram_oe      = ~cpu_rw;
      ram_we      = ~(wram_window & ~cpu_rw & m2) | wram_off;
   end

endmodule

// File: tb/tb_serial_bank_ctrl.sv
// Self-checking bench: directed loads with literal expectations plus a randomized run against a bit-count model.
module tb_serial_bank_ctrl;

   logic m2    = 1'b0;
   logic reset = 1'b1;

   serial_bank_ctrl_if bus ();

   logic [3:0] prg_addr;
   logic       prg_oe;
   logic [4:0] chr_addr;
   logic       ciram_a10;
   logic       ram_ce, ram_oe, ram_we;

   serial_bank_ctrl #(.PRG_FIXED_BANK(4'hF)) dut (
      .m2        (m2),
      .reset     (reset),
      .cpu_rw    (bus.cpu_rw),
      .cpu_data  (bus.cpu_data),
      .cpu_addr  (bus.cpu_addr),
      .ppu_addr  (bus.ppu_addr),
      .prg_addr  (prg_addr),
      .prg_oe    (prg_oe),
      .chr_addr  (chr_addr),
      .ciram_a10 (ciram_a10),
      .ram_ce    (ram_ce),
      .ram_oe    (ram_oe),
      .ram_we    (ram_we)
   );

   always #5 m2 = ~m2;

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: registers in an array, the partial load as a bit count plus accumulated bits.
   logic [4:0] m_reg [4];
   int         m_cnt  = 0;
   logic [4:0] m_acc  = 5'h0;
   logic       m_prev = 1'b0;
   bit         chk_en = 1'b0;

   always @(posedge m2) begin
      if (reset) begin
         m_reg[0] = 5'b01100;
         m_reg[1] = 5'h00;
         m_reg[2] = 5'h00;
         m_reg[3] = 5'h00;
         m_cnt    = 0;
         m_acc    = 5'h0;
         m_prev   = 1'b0;
         chk_en   = 1'b1;
      end else begin
         logic q;
         q = bus.cpu_addr[15] && !bus.cpu_rw;
         if (q && !m_prev) begin
            if (bus.cpu_data[7]) begin
               m_cnt    = 0;
               m_reg[0] = m_reg[0] | 5'b01100;
            end else begin
               m_acc[m_cnt] = bus.cpu_data[0];
               m_cnt++;
               if (m_cnt == 5) begin
                  m_reg[bus.cpu_addr[14:13]] = m_acc;
                  m_cnt = 0;
               end
            end
         end
         m_prev = q;
      end
   end

   function automatic logic [13:0] expect_out(logic mlevel);
      logic [4:0] c, ch0, ch1, p;
      logic [3:0] pa;
      logic [4:0] ca;
      logic       ci, win, prot, a12;
      c   = m_reg[0];
      ch0 = m_reg[1];
      ch1 = m_reg[2];
      p   = m_reg[3];
      if (c[3:2] < 2)       pa = {p[3:1], bus.cpu_addr[14]};
      else if (c[3:2] == 2) pa = bus.cpu_addr[14] ? p[3:0] : 4'h0;
      else                  pa = bus.cpu_addr[14] ? 4'hF : p[3:0];
      a12 = bus.ppu_addr[2];
      if (c[4] == 0) ca = {ch0[4:1], a12};
      else           ca = a12 ? ch1 : ch0;
      case (c[1:0])
         2'd0:    ci = 1'b0;
         2'd1:    ci = 1'b1;
         2'd2:    ci = bus.ppu_addr[0];
         default: ci = bus.ppu_addr[1];
      endcase
      win = (bus.cpu_addr[15:13] == 3'b011);
`ifdef WRAM_PROTECT_EN
      prot = p[4];
`else
      prot = 1'b0;
`endif
      return {pa, !(bus.cpu_addr[15] && bus.cpu_rw), ca, ci,
              !win || prot, !bus.cpu_rw, !(win && !bus.cpu_rw && mlevel) || prot};
   endfunction

   logic [13:0] dut_out;
   assign dut_out = {prg_addr, prg_oe, chr_addr, ciram_a10, ram_ce, ram_oe, ram_we};

   initial begin
      forever begin
         @(posedge m2);
         #2;
         if (chk_en) check("model_m2_high", dut_out, expect_out(1'b1));
         @(negedge m2);
         if (chk_en) check("model_m2_low", dut_out, expect_out(1'b0));
      end
   end

   task automatic drive(logic rw, logic [15:0] a, logic [7:0] d);
      @(negedge m2);
      #1;
      bus.cpu_rw   = rw;
      bus.cpu_addr = a;
      bus.cpu_data = d;
   endtask

   task automatic wr(logic [15:0] a, logic [7:0] d);
      drive(1'b0, a, d);
      drive(1'b1, 16'h0000, 8'h00);
   endtask

   task automatic load(logic [15:0] a, logic [4:0] v);
      for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
   endtask

   task automatic look(logic [15:0] a, logic [3:0] ppu);
      @(negedge m2);
      #1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_data = 8'h00;
      bus.ppu_addr = ppu;
      #1;
   endtask

   initial begin
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 16'h0000;
      bus.cpu_data = 8'h00;
      bus.ppu_addr = 4'h0;
      reset        = 1'b1;
      repeat (2) @(posedge m2);
      @(negedge m2);
      #1;
      reset = 1'b0;

      look(16'h8000, 4'b0100);
      check("rst_prg_8000", prg_addr, 4'h0);
      check("rst_chr", chr_addr, 5'h01);
      check("rst_ciram", ciram_a10, 1'b0);
      check("rst_prg_oe_read", prg_oe, 1'b0);
      check("rst_ram_ce_out", ram_ce, 1'b1);
      look(16'hC000, 4'b0000);
      check("rst_prg_c000", prg_addr, 4'hF);
      look(16'h6000, 4'b0000);
      check("rst_ram_ce_win", ram_ce, 1'b0);

      load(16'hE000, 5'b00110);
      look(16'h8000, 4'b0000);
      check("prg_load_8000", prg_addr, 4'h6);
      look(16'hC000, 4'b0000);
      check("prg_load_c000", prg_addr, 4'hF);

      wr(16'h8000, 8'h01);
      wr(16'h8000, 8'h00);
      wr(16'h8000, 8'h01);
      wr(16'h8000, 8'h80);
      load(16'h8000, 5'b11110);
      look(16'h8000, 4'b0001);
      check("clear_mode3_8000", prg_addr, 4'h6);
      check("clear_mirror_vert", ciram_a10, 1'b1);
      look(16'hC000, 4'b0101);
      check("clear_mode3_c000", prg_addr, 4'hF);

      drive(1'b0, 16'hC000, 8'h01);
      drive(1'b0, 16'hC000, 8'h00);
      drive(1'b1, 16'h0000, 8'h00);
      wr(16'hC000, 8'h00);
      wr(16'hC000, 8'h00);
      wr(16'hC000, 8'h00);
      look(16'h8000, 4'b0100);
      check("rmw_not_yet_committed", chr_addr, 5'h00);
      wr(16'hC000, 8'h01);
      look(16'h8000, 4'b0100);
      check("rmw_commit_chr1", chr_addr, 5'h11);

      load(16'h8000, 5'b10010);
      load(16'hA000, 5'h03);
      look(16'hC000, 4'b0000);
      check("chr4k_lo", chr_addr, 5'h03);
      check("mirror_a10_lo", ciram_a10, 1'b0);
      check("prg_mode0_c000", prg_addr, 4'h7);
      look(16'hC000, 4'b0101);
      check("chr4k_hi", chr_addr, 5'h11);
      check("mirror_a10_hi", ciram_a10, 1'b1);

      wr(16'hA000, 8'h01);
      wr(16'hA000, 8'h01);
      @(negedge m2);
      #1;
      reset        = 1'b1;
      bus.cpu_rw   = 1'b0;
      bus.cpu_addr = 16'hA000;
      bus.cpu_data = 8'h01;
      @(negedge m2);
      #1;
      reset        = 1'b0;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 16'h0000;
      look(16'h8000, 4'b0000);
      check("rst_mid_prg", prg_addr, 4'h0);
      check("rst_mid_chr", chr_addr, 5'h00);
      load(16'hA000, 5'h1F);
      look(16'h8000, 4'b0000);
      check("fresh_chr0_lo", chr_addr, 5'h1E);
      look(16'h8000, 4'b0100);
      check("fresh_chr0_hi", chr_addr, 5'h1F);

      load(16'hE000, 5'h10);
      drive(1'b0, 16'h6000, 8'h00);
      @(posedge m2);
      #2;
`ifdef WRAM_PROTECT_EN
      check("wram_prot_ce", ram_ce, 1'b1);
      check("wram_prot_we", ram_we, 1'b1);
`else
      check("wram_open_ce", ram_ce, 1'b0);
      check("wram_open_we", ram_we, 1'b0);
`endif
      drive(1'b1, 16'h0000, 8'h00);

      for (int n = 0; n < 3000; n++) begin
         logic [15:0] a;
         @(negedge m2);
         #1;
         case ($urandom_range(0, 5))
            0:       a = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
            1:       a = 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
            2:       a = 16'hC000 | 16'($urandom_range(0, 16'h1FFF));
            3:       a = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
            4:       a = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
            default: a = 16'($urandom_range(0, 16'hFFFF));
         endcase
         reset        = ($urandom_range(0, 199) == 0);
         bus.cpu_rw   = 1'($urandom_range(0, 1));
         bus.cpu_addr = a;
         bus.cpu_data = {($urandom_range(0, 11) == 0), 7'($urandom_range(0, 127))};
         bus.ppu_addr = 4'($urandom_range(0, 15));
      end
      @(negedge m2);
      #1;
      reset      = 1'b0;
      bus.cpu_rw = 1'b1;
      repeat (2) @(negedge m2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_bank_ctrl.md
# serial_bank_ctrl

Serial-loaded bank controller for the CPLD mapper boards. It sits between the CPU bus and the PRG ROM, CHR and WRAM address/enable pins that the board top-level routes. It accepts 1-bit-per-write serial register loads at $8000–$FFFF, commits each completed 5-bit value to one of four configuration registers, and drives the PRG/CHR bank lines, the nametable mirroring line and the WRAM strobes from those registers.

## Interface
Parameters:
- `PRG_FIXED_BANK`, default 4'hF: bank mapped at $C000 in PRG mode 3.

Ports:
- `m2`  in  1  CPU M2; the sole clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_rw`  in  1  CPU R/W; 1 = read.
- `cpu_data`  in  8  CPU data bus.
- `cpu_addr`  in  16  CPU address; bit 15 is `~romsel_n`, supplied by the top-level.
- `ppu_addr`  in  4  PPU A13..A10.
- `prg_addr`  out  4  PRG ROM A17..A14.
- `prg_oe`  out  1  PRG ROM /OE.
- `chr_addr`  out  5  CHR A16..A12.
- `ciram_a10`  out  1  nametable select.
- `ram_ce`, `ram_oe`, `ram_we`  out  1 each  WRAM strobes, active-low.

## Operation
- A qualifying write is `cpu_addr[15] & ~cpu_rw`, sampled on the `m2` rising edge.
- `prev_wr` flop is set by every qualifying write and cleared otherwise. A qualifying write with `prev_wr`=1 is ignored entirely, which rejects RMW double writes.
- Accepted write with `cpu_data[7]`=1: `shift` <= 5'b10000; `ctrl` <= `ctrl | 5'b01100`.
- Accepted write with `cpu_data[7]`=0 and `shift[0]`=0: `shift` <= {`cpu_data[0]`, `shift[4:1]`}.
- Accepted write with `cpu_data[7]`=0 and `shift[0]`=1 (fifth bit): value {`cpu_data[0]`, `shift[4:1]`} commits to the register selected by `cpu_addr[14:13]`. The selection is 0 = `ctrl`, 1 = `chr0`, 2 = `chr1`, 3 = `prg`. `shift` then resets to 5'b10000.
- Register fields:
  - `ctrl[1:0]` is mirroring.
  - `ctrl[3:2]` is PRG mode.
  - `ctrl[4]` is CHR mode.
  - `prg[3:0]` is the PRG bank.
  - `prg[4]` is WRAM disable.
- PRG mapping, for modes 0 and 1: `prg_addr` = {`prg[3:1]`, `cpu_addr[14]`}.
- PRG mapping, mode 2: $8000 → 0, $C000 → `prg[3:0]`.
- PRG mapping, mode 3: $8000 → `prg[3:0]`, $C000 → `PRG_FIXED_BANK`.
- `prg_oe` = ~(`cpu_addr[15]` & `cpu_rw`).
- CHR mapping, `ctrl[4]`=0: `chr_addr` = {`chr0[4:1]`, `ppu_addr[12]`}.
- CHR mapping, `ctrl[4]`=1: `chr_addr` = `ppu_addr[12]` ? `chr1` : `chr0`.
- `ciram_a10` by mirroring value: 0 → 0; 1 → 1; 2 → `ppu_addr[10]`; 3 → `ppu_addr[11]`.
- WRAM window is `cpu_addr[15:13]`==3'b011.
  - `ram_ce` = ~window.
  - `ram_oe` = ~`cpu_rw`.
  - `ram_we` = ~(window & ~`cpu_rw` & `m2`).

## Timing
- Register effects are visible one `m2` edge after the accepting write. Mapping outputs are combinational from the registers and the buses.
- Reset values:
  - `shift`=5'b10000, `prev_wr`=0, `ctrl`=5'b01100, `chr0`=`chr1`=`prg`=0.
  - Hence at reset, `prg_addr` = 0 for $8000 and 4'hF for $C000.
  - Also at reset, `chr_addr` = {4'h0, `ppu_addr[12]`} and `ciram_a10`=0.
  - `ram_ce`=0 only inside the window; `prg_oe` follows the bus.
- Reset asserted mid-sequence discards the partial `shift` and restores all reset values on that edge. A write on the same edge as `reset` is ignored.
- A reset-bit write is also subject to `prev_wr` filtering.
- Five accepted writes complete a load. Writes spaced by non-write cycles are never lost.

## Configuration
- `WRAM_PROTECT_EN` defined: `prg[4]`=1 forces `ram_ce`=1 and `ram_we`=1.
- `WRAM_PROTECT_EN` undefined: `prg[4]` is stored but ignored, and WRAM is always enabled in its window.

## Structure
- `mapper_pkg` holds:
  - register-index constants (`REG_CTRL`, `REG_CHR0`, `REG_CHR1`, `REG_PRG`);
  - PRG and mirroring mode encodings;
  - `SHIFT_EMPTY`=5'b10000 and `CTRL_RESET`=5'b01100.
- Sub-module `serial_loader`: write qualification, `prev_wr` filter and shift register. It outputs a one-cycle `commit` pulse with a 5-bit value and a 2-bit index. The parent holds the registers and all decode.

## Test plan
- Write bits 0,1,1,0,0 (LSB first, with an idle cycle between writes) to $E000 → `prg`=5'b00110. A read at $8000 then gives `prg_addr`=4'h6, and a read at $C000 gives 4'hF.
- Write $80 to $8000 after three partial bits → `shift` is reset. The next five writes commit cleanly and `ctrl[3:2]` reads 2'b11.
- Two back-to-back qualifying writes with no idle cycle between them → the second is ignored, and the load completes only after five non-consecutive writes.
- Load `ctrl`=5'b10010, `chr0`=5'h03, `chr1`=5'h11:
  - `ppu_addr`=4'b0000 → `chr_addr`=5'h03, `ciram_a10`=0;
  - `ppu_addr`=4'b0101 → `chr_addr`=5'h11, `ciram_a10`=1.
- Assert `reset` after two partial writes → all reset values are restored. Five fresh writes of 1 to $A000 then give `chr0`=5'h1F.
- With `WRAM_PROTECT_EN` defined, load `prg`=5'h10 and write $6000 → `ram_ce`=1 and `ram_we`=1. Undefined: `ram_we`=0 while `m2` is high.
